// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the per-warp fetch PC owner.
//
// The warp count, address width and epoch width are fixed here. The fetch
// request struct and the warp FSM enum are built from them.
// The hold length of a misprediction stall is a module parameter.
// Its default lives here.
package fetch_redirect_ctrl_pkg;

  localparam int NUM_WARPS             = 4;
  localparam int WARP_ID_WIDTH         = $clog2(NUM_WARPS);
  localparam int ADDR_WIDTH            = 32;
  localparam int EPOCH_WIDTH           = 2;
  localparam int REDIRECT_HOLD_DEFAULT = 2;

  // Sequential fetch advances by one 4-byte instruction.
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } warp_fsm_e;

  typedef struct packed {
    logic [WARP_ID_WIDTH-1:0] warp_id;
    logic [ADDR_WIDTH-1:0]    pc;
    logic [EPOCH_WIDTH-1:0]   epoch;
  } fetch_req_t;

  // A hold of 0 cycles still needs a legal (1-bit) counter.
  function automatic int hold_cnt_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_warp_pc_slot.sv
// warp_pc_slot: the FSM, PC, epoch and post-misprediction hold counter
// for one warp.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_start/i_start_pc  launch or restart the warp at i_start_pc
//   i_stop              retire the warp; this beats every other event
//   i_mispredict        execute-stage redirect to i_correct_pc
//   i_predict           decode predicted-taken redirect for this warp,
//                       carrying i_predict_target and i_predict_epoch
//   i_accept            a fetch of this warp was accepted this cycle
//   o_pc, o_epoch       current PC and epoch
//   o_fetchable         warp is in RUN
//   o_flush             registered pulse: the epoch bumped last edge
module warp_pc_slot
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int REDIRECT_HOLD = REDIRECT_HOLD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [ADDR_WIDTH-1:0]  i_start_pc,
  input  logic                   i_stop,
  input  logic                   i_mispredict,
  input  logic [ADDR_WIDTH-1:0]  i_correct_pc,
  input  logic                   i_predict,
  input  logic [ADDR_WIDTH-1:0]  i_predict_target,
  input  logic [EPOCH_WIDTH-1:0] i_predict_epoch,
  input  logic                   i_accept,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [EPOCH_WIDTH-1:0] o_epoch,
  output logic                   o_fetchable,
  output logic                   o_flush
);

  localparam int              CNT_W     = hold_cnt_width(REDIRECT_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(REDIRECT_HOLD);

  warp_fsm_e               r_state;
  warp_fsm_e               w_next_state;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [ADDR_WIDTH-1:0]   w_next_pc;
  logic [EPOCH_WIDTH-1:0]  r_epoch;
  logic [CNT_W-1:0]        r_hold_cnt;
  logic [CNT_W-1:0]        w_next_cnt;
  logic                    r_flush;
  logic                    w_live;
  logic                    w_mispredict_hit;
  logic                    w_predict_hit;
  logic                    w_bump;

  assign w_live           = (r_state != IDLE);
  assign w_mispredict_hit = i_mispredict && w_live;
  // A branch decoded under an older epoch is on a squashed path, so ignore it.
  assign w_predict_hit    = i_predict && w_live && (i_predict_epoch == r_epoch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Event priority is stop > start > misprediction.
  // A predicted redirect never changes the FSM state.
  // The hold countdown continues under a predicted redirect.
  always_comb begin
    w_next_state = r_state;
    if (i_stop) begin
      w_next_state = IDLE;
    end else if (i_start) begin
      w_next_state = RUN;
    end else if (w_mispredict_hit) begin
      w_next_state = (REDIRECT_HOLD > 0) ? HOLD : RUN;
    end else if ((r_state == HOLD) && (r_hold_cnt <= CNT_W'(1))) begin
      w_next_state = RUN;
    end
  end

  // A start from IDLE is a fresh launch and keeps the epoch.
  // A restart of a live warp is a redirect, so the epoch bumps.
  always_comb begin
    o_fetchable = (r_state == RUN);
    w_bump      = 1'b0;
    if (!i_stop) begin
      if (i_start) begin
        w_bump = w_live;
      end else begin
        w_bump = w_mispredict_hit || w_predict_hit;
      end
    end
  end

  always_comb begin
    w_next_pc  = r_pc;
    w_next_cnt = r_hold_cnt;
    if (i_stop) begin
      w_next_cnt = '0;
    end else if (i_start) begin
      w_next_pc  = i_start_pc;
      w_next_cnt = '0;
    end else if (w_mispredict_hit) begin
      w_next_pc  = i_correct_pc;
      w_next_cnt = HOLD_LOAD;
    end else begin
      if ((r_state == HOLD) && (r_hold_cnt != '0)) begin
        w_next_cnt = r_hold_cnt - CNT_W'(1);
      end
      if (w_predict_hit) begin
        w_next_pc = i_predict_target;
      end else if (i_accept) begin
        w_next_pc = r_pc + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_epoch    <= '0;
      r_hold_cnt <= '0;
      r_flush    <= 1'b0;
    end else begin
      r_pc       <= w_next_pc;
      r_epoch    <= r_epoch + EPOCH_WIDTH'(w_bump);
      r_hold_cnt <= w_next_cnt;
      r_flush    <= w_bump;
    end
  end

  assign o_pc    = r_pc;
  assign o_epoch = r_epoch;
  assign o_flush = r_flush;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: owns the fetch PC of every warp.
// It issues epoch-tagged fetch requests to the instruction cache.
// It applies predicted-taken and misprediction redirects.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_warp_start*/i_warp_stop*  warp launch/restart and retire
//   i_sched_valid/_warp_id      scheduler fetch request
//   o_sched_ready               combinational accept
//   o_fetch_req_*               one-entry registered request
//   i_fetch_req_ready           icache handshake for that request
//   i_predict_*                 decode-stage branch prediction
//   i_misprediction, i_mispredict_warp_id, i_correct_pc
//                               execute-stage redirect
//   o_flush_mask                per-warp 1-cycle pulse on an epoch bump
//   o_warp_epoch                packed per-warp epochs, warp 0 in the LSBs
//   o_warp_fetchable            per-warp RUN indication
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int REDIRECT_HOLD = REDIRECT_HOLD_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_warp_start,
  input  logic [WARP_ID_WIDTH-1:0]           i_warp_start_id,
  input  logic [ADDR_WIDTH-1:0]              i_warp_start_pc,
  input  logic                               i_warp_stop,
  input  logic [WARP_ID_WIDTH-1:0]           i_warp_stop_id,
  input  logic                               i_sched_valid,
  input  logic [WARP_ID_WIDTH-1:0]           i_sched_warp_id,
  output logic                               o_sched_ready,
  output logic                               o_fetch_req_valid,
  input  logic                               i_fetch_req_ready,
  output logic [WARP_ID_WIDTH-1:0]           o_fetch_req_warp_id,
  output logic [ADDR_WIDTH-1:0]              o_fetch_req_pc,
  output logic [EPOCH_WIDTH-1:0]             o_fetch_req_epoch,
  input  logic                               i_predict_valid,
  input  logic [WARP_ID_WIDTH-1:0]           i_predict_warp_id,
  input  logic                               i_predict_taken,
  input  logic [ADDR_WIDTH-1:0]              i_predict_target,
  input  logic [EPOCH_WIDTH-1:0]             i_predict_epoch,
  input  logic                               i_misprediction,
  input  logic [WARP_ID_WIDTH-1:0]           i_mispredict_warp_id,
  input  logic [ADDR_WIDTH-1:0]              i_correct_pc,
  output logic [NUM_WARPS-1:0]               o_flush_mask,
  output logic [NUM_WARPS*EPOCH_WIDTH-1:0]   o_warp_epoch,
  output logic [NUM_WARPS-1:0]               o_warp_fetchable
);

  logic [ADDR_WIDTH-1:0]  w_pc    [NUM_WARPS];
  logic [EPOCH_WIDTH-1:0] w_epoch [NUM_WARPS];
  logic [NUM_WARPS-1:0]   w_fetchable;
  logic [NUM_WARPS-1:0]   w_flush;
  logic                   w_slot_free;
  logic                   w_accept;
  fetch_req_t             r_req;
  logic                   r_req_valid;

  // The output register can take a new request when it is empty.
  // It can also take one when its current request drains this cycle.
  assign w_slot_free   = !r_req_valid || i_fetch_req_ready;
  assign o_sched_ready = w_fetchable[i_sched_warp_id] && w_slot_free;
  assign w_accept      = i_sched_valid && o_sched_ready;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_slot
    logic w_start_hit;
    logic w_stop_hit;
    logic w_mispredict_hit;
    logic w_predict_hit;
    logic w_accept_hit;

    assign w_start_hit      = i_warp_start && (i_warp_start_id == WARP_ID_WIDTH'(g));
    assign w_stop_hit       = i_warp_stop && (i_warp_stop_id == WARP_ID_WIDTH'(g));
    assign w_mispredict_hit = i_misprediction && (i_mispredict_warp_id == WARP_ID_WIDTH'(g));
    assign w_predict_hit    = i_predict_valid && i_predict_taken &&
                              (i_predict_warp_id == WARP_ID_WIDTH'(g));
    assign w_accept_hit     = w_accept && (i_sched_warp_id == WARP_ID_WIDTH'(g));

    warp_pc_slot #(
      .REDIRECT_HOLD(REDIRECT_HOLD)
    ) u_slot (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_start         (w_start_hit),
      .i_start_pc      (i_warp_start_pc),
      .i_stop          (w_stop_hit),
      .i_mispredict    (w_mispredict_hit),
      .i_correct_pc    (i_correct_pc),
      .i_predict       (w_predict_hit),
      .i_predict_target(i_predict_target),
      .i_predict_epoch (i_predict_epoch),
      .i_accept        (w_accept_hit),
      .o_pc            (w_pc[g]),
      .o_epoch         (w_epoch[g]),
      .o_fetchable     (w_fetchable[g]),
      .o_flush         (w_flush[g])
    );

    assign o_warp_epoch[g*EPOCH_WIDTH +: EPOCH_WIDTH] = w_epoch[g];
  end

  // The request captures the pre-update pc/epoch of the warp.
  // A held request is never killed. A redirect that lands while it waits
  // leaves it tagged with the old epoch, and downstream drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_valid <= 1'b0;
      r_req       <= '0;
    end else if (w_accept) begin
      r_req_valid <= 1'b1;
      r_req       <= '{warp_id: i_sched_warp_id,
                       pc:      w_pc[i_sched_warp_id],
                       epoch:   w_epoch[i_sched_warp_id]};
    end else if (i_fetch_req_ready) begin
      r_req_valid <= 1'b0;
    end
  end

  assign o_fetch_req_valid   = r_req_valid;
  assign o_fetch_req_warp_id = r_req.warp_id;
  assign o_fetch_req_pc      = r_req.pc;
  assign o_fetch_req_epoch   = r_req.epoch;
  assign o_flush_mask        = w_flush;
  assign o_warp_fetchable    = w_fetchable;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl.
// Directed scenarios compare against hand-derived constants.
// The randomized phase compares against a behavioural per-warp model.
// The model tracks alive/hold-remaining/pc/epoch and a one-entry request.
module tb_fetch_redirect_ctrl;

  localparam int HOLD = 2;

  logic        clk;
  logic        rstN;
  logic        warpStart;
  logic [1:0]  warpStartId;
  logic [31:0] warpStartPc;
  logic        warpStop;
  logic [1:0]  warpStopId;
  logic        schedValid;
  logic [1:0]  schedWarpId;
  logic        schedReady;
  logic        fetchReqValid;
  logic        fetchReqReady;
  logic [1:0]  fetchReqWarpId;
  logic [31:0] fetchReqPc;
  logic [1:0]  fetchReqEpoch;
  logic        predictValid;
  logic [1:0]  predictWarpId;
  logic        predictTaken;
  logic [31:0] predictTarget;
  logic [1:0]  predictEpoch;
  logic        misprediction;
  logic [1:0]  mispredictWarpId;
  logic [31:0] correctPc;
  logic [3:0]  flushMask;
  logic [7:0]  warpEpoch;
  logic [3:0]  warpFetchable;

  int totalChecks = 0;
  int badChecks   = 0;

  // Behavioural reference model
  bit          mAlive    [4];
  int          mHoldLeft [4];
  logic [31:0] mPc       [4];
  int          mEpoch    [4];
  logic [3:0]  mFlush;
  bit          mReqValid;
  logic [1:0]  mReqId;
  logic [31:0] mReqPc;
  int          mReqEpoch;

  fetch_redirect_ctrl #(.REDIRECT_HOLD(HOLD)) dut (
    .clk                 (clk),
    .rst_n               (rstN),
    .i_warp_start        (warpStart),
    .i_warp_start_id     (warpStartId),
    .i_warp_start_pc     (warpStartPc),
    .i_warp_stop         (warpStop),
    .i_warp_stop_id      (warpStopId),
    .i_sched_valid       (schedValid),
    .i_sched_warp_id     (schedWarpId),
    .o_sched_ready       (schedReady),
    .o_fetch_req_valid   (fetchReqValid),
    .i_fetch_req_ready   (fetchReqReady),
    .o_fetch_req_warp_id (fetchReqWarpId),
    .o_fetch_req_pc      (fetchReqPc),
    .o_fetch_req_epoch   (fetchReqEpoch),
    .i_predict_valid     (predictValid),
    .i_predict_warp_id   (predictWarpId),
    .i_predict_taken     (predictTaken),
    .i_predict_target    (predictTarget),
    .i_predict_epoch     (predictEpoch),
    .i_misprediction     (misprediction),
    .i_mispredict_warp_id(mispredictWarpId),
    .i_correct_pc        (correctPc),
    .o_flush_mask        (flushMask),
    .o_warp_epoch        (warpEpoch),
    .o_warp_fetchable    (warpFetchable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    for (int w = 0; w < 4; w++) begin
      mAlive[w] = 0; mHoldLeft[w] = 0; mPc[w] = '0; mEpoch[w] = 0;
    end
    mFlush = '0; mReqValid = 0; mReqId = '0; mReqPc = '0; mReqEpoch = 0;
  endtask

  function automatic bit modelReady();
    return mAlive[schedWarpId] && (mHoldLeft[schedWarpId] == 0) && (!mReqValid || fetchReqReady);
  endfunction

  // Advance the model by one clock from the current inputs.
  task automatic modelStep();
    bit acc;
    int accId;
    acc   = schedValid && modelReady();
    accId = int'(schedWarpId);
    if (acc) begin
      mReqValid = 1; mReqId = schedWarpId; mReqPc = mPc[accId]; mReqEpoch = mEpoch[accId];
    end else if (fetchReqReady) begin
      mReqValid = 0;
    end
    for (int w = 0; w < 4; w++) begin
      mFlush[w] = 1'b0;
      if (warpStop && int'(warpStopId) == w) begin
        mAlive[w] = 0; mHoldLeft[w] = 0;
      end else if (warpStart && int'(warpStartId) == w) begin
        if (mAlive[w]) begin mEpoch[w] = (mEpoch[w] + 1) % 4; mFlush[w] = 1'b1; end
        mAlive[w] = 1; mHoldLeft[w] = 0; mPc[w] = warpStartPc;
      end else if (misprediction && int'(mispredictWarpId) == w && mAlive[w]) begin
        mPc[w] = correctPc; mEpoch[w] = (mEpoch[w] + 1) % 4; mFlush[w] = 1'b1; mHoldLeft[w] = HOLD;
      end else begin
        if (mHoldLeft[w] > 0) mHoldLeft[w]--;
        if (predictValid && predictTaken && int'(predictWarpId) == w && mAlive[w] &&
            int'(predictEpoch) == mEpoch[w]) begin
          mPc[w] = predictTarget; mEpoch[w] = (mEpoch[w] + 1) % 4; mFlush[w] = 1'b1;
        end else if (acc && accId == w) begin
          mPc[w] = mPc[w] + 32'd4;
        end
      end
    end
  endtask

  // Inputs are driven at the negedge; one tick clocks them in and returns at the next negedge.
  task automatic tick();
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clearInputs();
    warpStart = 0; warpStartId = '0; warpStartPc = '0;
    warpStop = 0; warpStopId = '0;
    schedValid = 0; schedWarpId = '0; fetchReqReady = 1;
    predictValid = 0; predictWarpId = '0; predictTaken = 0; predictTarget = '0; predictEpoch = '0;
    misprediction = 0; mispredictWarpId = '0; correctPc = '0;
  endtask

  task automatic applyStimulus();
    warpStart     = ($urandom_range(0, 7) == 0);
    warpStartId   = 2'($urandom_range(0, 3));
    warpStartPc   = $urandom;
    warpStop      = ($urandom_range(0, 15) == 0);
    warpStopId    = 2'($urandom_range(0, 3));
    schedValid    = ($urandom_range(0, 3) != 0);
    schedWarpId   = 2'($urandom_range(0, 3));
    fetchReqReady = ($urandom_range(0, 3) != 0);
    predictValid  = ($urandom_range(0, 2) == 0);
    predictWarpId = 2'($urandom_range(0, 3));
    predictTaken  = 1'($urandom_range(0, 1));
    predictTarget = $urandom;
    predictEpoch  = ($urandom_range(0, 1) == 0) ? 2'(mEpoch[predictWarpId]) : 2'($urandom_range(0, 3));
    misprediction = ($urandom_range(0, 7) == 0);
    mispredictWarpId = 2'($urandom_range(0, 3));
    correctPc     = $urandom;
  endtask

  task automatic test_reset();
    clearInputs();
    rstN = 0;
    modelReset();
    schedValid = 1; schedWarpId = 2'd1;
    #12;
    totalChecks++; if (fetchReqValid !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_req_valid: got %b want 0", fetchReqValid); end
    totalChecks++; if ({fetchReqWarpId, fetchReqPc, fetchReqEpoch} !== 36'h0) begin badChecks++; $display("[TB] FAIL reset_req_fields: got %h want 0", {fetchReqWarpId, fetchReqPc, fetchReqEpoch}); end
    totalChecks++; if ({flushMask, warpEpoch, warpFetchable} !== 16'h0) begin badChecks++; $display("[TB] FAIL reset_warp_outputs: got %h want 0", {flushMask, warpEpoch, warpFetchable}); end
    totalChecks++; if (schedReady !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_sched_ready: got %b want 0", schedReady); end
    @(negedge clk);
    rstN = 1;
    clearInputs();
    @(negedge clk);
  endtask

  task automatic test_fetch();
    warpStart = 1; warpStartId = 2'd1; warpStartPc = 32'h100;
    tick();
    warpStart = 0;
    totalChecks++; if (warpFetchable !== 4'b0010) begin badChecks++; $display("[TB] FAIL start_fetchable: got %b want 0010", warpFetchable); end
    totalChecks++; if (flushMask !== 4'b0000) begin badChecks++; $display("[TB] FAIL start_idle_noflush: got %b want 0000", flushMask); end
    schedValid = 1; schedWarpId = 2'd1; fetchReqReady = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      totalChecks++; if (schedReady !== 1'b1) begin badChecks++; $display("[TB] FAIL fetch_sched_ready[%0d]: got %b want 1", i, schedReady); end
      tick();
      totalChecks++; if ({fetchReqValid, fetchReqWarpId, fetchReqPc, fetchReqEpoch} !== {1'b1, 2'd1, 32'h100 + 32'(4 * i), 2'd0})
        begin badChecks++; $display("[TB] FAIL fetch_seq[%0d]: got v=%b w=%0d pc=%h e=%0d want v=1 w=1 pc=%h e=0", i, fetchReqValid, fetchReqWarpId, fetchReqPc, fetchReqEpoch, 32'h100 + 32'(4 * i)); end
    end
    schedValid = 0;
    tick();
    totalChecks++; if (fetchReqValid !== 1'b0) begin badChecks++; $display("[TB] FAIL fetch_drain: got %b want 0", fetchReqValid); end
  endtask

  task automatic test_predict();
    predictValid = 1; predictWarpId = 2'd1; predictTaken = 1; predictTarget = 32'h80; predictEpoch = 2'd0;
    tick();
    predictValid = 0;
    totalChecks++; if (flushMask !== 4'b0010) begin badChecks++; $display("[TB] FAIL predict_flush: got %b want 0010", flushMask); end
    totalChecks++; if (warpEpoch[3:2] !== 2'd1) begin badChecks++; $display("[TB] FAIL predict_epoch: got %0d want 1", warpEpoch[3:2]); end
    schedValid = 1; schedWarpId = 2'd1;
    tick();
    schedValid = 0;
    totalChecks++; if ({fetchReqPc, fetchReqEpoch} !== {32'h80, 2'd1}) begin badChecks++; $display("[TB] FAIL predict_fetch: got pc=%h e=%0d want pc=80 e=1", fetchReqPc, fetchReqEpoch); end
    totalChecks++; if (flushMask !== 4'b0000) begin badChecks++; $display("[TB] FAIL flush_pulse_width: got %b want 0000", flushMask); end
    predictValid = 1; predictTarget = 32'h999; predictEpoch = 2'd3;
    tick();
    predictValid = 0;
    totalChecks++; if (flushMask !== 4'b0000) begin badChecks++; $display("[TB] FAIL stale_predict_flush: got %b want 0000", flushMask); end
    totalChecks++; if (warpEpoch[3:2] !== 2'd1) begin badChecks++; $display("[TB] FAIL stale_predict_epoch: got %0d want 1", warpEpoch[3:2]); end
    schedValid = 1;
    tick();
    schedValid = 0;
    totalChecks++; if ({fetchReqPc, fetchReqEpoch} !== {32'h84, 2'd1}) begin badChecks++; $display("[TB] FAIL stale_predict_fetch: got pc=%h e=%0d want pc=84 e=1", fetchReqPc, fetchReqEpoch); end
    tick();
  endtask

  task automatic test_mispredict();
    misprediction = 1; mispredictWarpId = 2'd1; correctPc = 32'h200;
    tick();
    misprediction = 0;
    totalChecks++; if (flushMask !== 4'b0010) begin badChecks++; $display("[TB] FAIL mispredict_flush: got %b want 0010", flushMask); end
    totalChecks++; if (warpEpoch[3:2] !== 2'd2) begin badChecks++; $display("[TB] FAIL mispredict_epoch: got %0d want 2", warpEpoch[3:2]); end
    schedValid = 1; schedWarpId = 2'd1;
    for (int i = 0; i < HOLD; i++) begin
      #1;
      totalChecks++; if (warpFetchable[1] !== 1'b0) begin badChecks++; $display("[TB] FAIL hold_fetchable[%0d]: got %b want 0", i, warpFetchable[1]); end
      totalChecks++; if (schedReady !== 1'b0) begin badChecks++; $display("[TB] FAIL hold_sched_ready[%0d]: got %b want 0", i, schedReady); end
      tick();
    end
    totalChecks++; if (schedReady !== 1'b1) begin badChecks++; $display("[TB] FAIL hold_release: got %b want 1", schedReady); end
    tick();
    schedValid = 0;
    totalChecks++; if ({fetchReqValid, fetchReqPc, fetchReqEpoch} !== {1'b1, 32'h200, 2'd2}) begin badChecks++; $display("[TB] FAIL mispredict_fetch: got v=%b pc=%h e=%0d want v=1 pc=200 e=2", fetchReqValid, fetchReqPc, fetchReqEpoch); end
    tick();
  endtask

  task automatic test_same_cycle();
    warpStart = 1; warpStartId = 2'd0; warpStartPc = 32'h1000;
    tick();
    warpStartId = 2'd2; warpStartPc = 32'h2000;
    tick();
    warpStart = 0;
    misprediction = 1; mispredictWarpId = 2'd2; correctPc = 32'h300;
    predictValid = 1; predictWarpId = 2'd2; predictTaken = 1; predictTarget = 32'h400; predictEpoch = 2'd0;
    tick();
    misprediction = 0; predictValid = 0;
    totalChecks++; if (flushMask !== 4'b0100) begin badChecks++; $display("[TB] FAIL same_warp_flush: got %b want 0100", flushMask); end
    totalChecks++; if (warpEpoch[5:4] !== 2'd1) begin badChecks++; $display("[TB] FAIL same_warp_epoch: got %0d want 1", warpEpoch[5:4]); end
    tick(); tick();
    schedValid = 1; schedWarpId = 2'd2;
    tick();
    schedValid = 0;
    totalChecks++; if ({fetchReqPc, fetchReqEpoch} !== {32'h300, 2'd1}) begin badChecks++; $display("[TB] FAIL same_warp_fetch: got pc=%h e=%0d want pc=300 e=1", fetchReqPc, fetchReqEpoch); end
    misprediction = 1; mispredictWarpId = 2'd2; correctPc = 32'h500;
    predictValid = 1; predictWarpId = 2'd0; predictTaken = 1; predictTarget = 32'h600; predictEpoch = 2'd0;
    tick();
    misprediction = 0; predictValid = 0;
    totalChecks++; if (flushMask !== 4'b0101) begin badChecks++; $display("[TB] FAIL multi_warp_flush: got %b want 0101", flushMask); end
    totalChecks++; if ({warpEpoch[5:4], warpEpoch[1:0]} !== {2'd2, 2'd1}) begin badChecks++; $display("[TB] FAIL multi_warp_epoch: got %b want 1001", {warpEpoch[5:4], warpEpoch[1:0]}); end
    schedValid = 1; schedWarpId = 2'd0;
    tick();
    schedValid = 0;
    totalChecks++; if ({fetchReqWarpId, fetchReqPc, fetchReqEpoch} !== {2'd0, 32'h600, 2'd1}) begin badChecks++; $display("[TB] FAIL multi_warp_fetch: got w=%0d pc=%h e=%0d want w=0 pc=600 e=1", fetchReqWarpId, fetchReqPc, fetchReqEpoch); end
    tick();
  endtask

  task automatic test_back_to_back();
    schedValid = 1; schedWarpId = 2'd1; fetchReqReady = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      misprediction = (i == 1); mispredictWarpId = 2'd1; correctPc = 32'h700;
      #1;
      totalChecks++; if (schedReady !== 1'b0) begin badChecks++; $display("[TB] FAIL stall_sched_ready[%0d]: got %b want 0", i, schedReady); end
      totalChecks++; if ({fetchReqValid, fetchReqWarpId, fetchReqPc, fetchReqEpoch} !== {1'b1, 2'd1, 32'h204, 2'd2})
        begin badChecks++; $display("[TB] FAIL stall_stable[%0d]: got v=%b w=%0d pc=%h e=%0d want v=1 w=1 pc=204 e=2", i, fetchReqValid, fetchReqWarpId, fetchReqPc, fetchReqEpoch); end
      tick();
    end
    misprediction = 0; schedValid = 0; fetchReqReady = 1;
    totalChecks++; if ({fetchReqValid, fetchReqEpoch, warpEpoch[3:2]} !== {1'b1, 2'd2, 2'd3}) begin badChecks++; $display("[TB] FAIL stall_old_epoch: got v=%b e=%0d warp=%0d want v=1 e=2 warp=3", fetchReqValid, fetchReqEpoch, warpEpoch[3:2]); end
    tick();
    totalChecks++; if (fetchReqValid !== 1'b0) begin badChecks++; $display("[TB] FAIL stall_drain: got %b want 0", fetchReqValid); end
  endtask

  task automatic test_wrap_stop();
    warpStart = 1; warpStartId = 2'd3; warpStartPc = 32'h3000;
    tick();
    warpStart = 0;
    for (int i = 0; i < 4; i++) begin
      misprediction = 1; mispredictWarpId = 2'd3; correctPc = 32'h3100 + 32'(i);
      tick();
      totalChecks++; if ({flushMask, warpEpoch[7:6]} !== {4'b1000, 2'((i + 1) % 4)}) begin badChecks++; $display("[TB] FAIL epoch_wrap[%0d]: got flush=%b e=%0d want flush=1000 e=%0d", i, flushMask, warpEpoch[7:6], (i + 1) % 4); end
    end
    warpStop = 1; warpStopId = 2'd3;
    tick();
    warpStop = 0; misprediction = 0;
    totalChecks++; if ({flushMask, warpFetchable[3], warpEpoch[7:6]} !== {4'b0000, 1'b0, 2'd0}) begin badChecks++; $display("[TB] FAIL stop_wins: got flush=%b fetchable=%b e=%0d want 0000 0 0", flushMask, warpFetchable[3], warpEpoch[7:6]); end
    tick(); tick();
    totalChecks++; if (warpFetchable[3] !== 1'b0) begin badChecks++; $display("[TB] FAIL stop_stays_idle: got %b want 0", warpFetchable[3]); end
  endtask

  task automatic checkOutput(input int cyc);
    logic [7:0] expEpochs;
    logic [3:0] expFetchable;
    for (int w = 0; w < 4; w++) begin
      expEpochs[w*2 +: 2] = 2'(mEpoch[w]);
      expFetchable[w] = mAlive[w] && (mHoldLeft[w] == 0);
    end
    totalChecks++; if (fetchReqValid !== mReqValid || (mReqValid && {fetchReqWarpId, fetchReqPc, fetchReqEpoch} !== {mReqId, mReqPc, 2'(mReqEpoch)}))
      begin badChecks++; $display("[TB] FAIL rand_req[%0d]: got v=%b w=%0d pc=%h e=%0d want v=%b w=%0d pc=%h e=%0d", cyc, fetchReqValid, fetchReqWarpId, fetchReqPc, fetchReqEpoch, mReqValid, mReqId, mReqPc, mReqEpoch); end
    totalChecks++; if ({flushMask, warpEpoch, warpFetchable} !== {mFlush, expEpochs, expFetchable})
      begin badChecks++; $display("[TB] FAIL rand_warps[%0d]: got flush=%b ep=%h fe=%b want flush=%b ep=%h fe=%b", cyc, flushMask, warpEpoch, warpFetchable, mFlush, expEpochs, expFetchable); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      applyStimulus();
      #1;
      totalChecks++; if (schedReady !== modelReady()) begin badChecks++; $display("[TB] FAIL rand_sched_ready[%0d]: got %b want %b", cyc, schedReady, modelReady()); end
      tick();
      checkOutput(cyc);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_reset_mid_hold();
    warpStart = 1; warpStartId = 2'd1; warpStartPc = 32'h40;
    tick();
    warpStart = 0;
    schedValid = 1; schedWarpId = 2'd1; fetchReqReady = 0;
    tick();
    schedValid = 0;
    misprediction = 1; mispredictWarpId = 2'd1; correctPc = 32'h900;
    tick();
    misprediction = 0;
    totalChecks++; if ({warpFetchable[1], flushMask[1], fetchReqValid} !== 3'b011) begin badChecks++; $display("[TB] FAIL pre_reset_hold: got %b want 011", {warpFetchable[1], flushMask[1], fetchReqValid}); end
    #2 rstN = 0;
    modelReset();
    #1;
    totalChecks++; if ({fetchReqValid, fetchReqWarpId, fetchReqPc, fetchReqEpoch, flushMask, warpEpoch, warpFetchable, schedReady} !== 54'h0)
      begin badChecks++; $display("[TB] FAIL async_reset: got v=%b pc=%h flush=%b ep=%h fe=%b rdy=%b want all 0", fetchReqValid, fetchReqPc, flushMask, warpEpoch, warpFetchable, schedReady); end
    @(negedge clk);
    rstN = 1;
    clearInputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_predict();
    test_mispredict();
    test_same_cycle();
    test_back_to_back();
    test_wrap_stop();
    test_random();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
